streaming_operand_serializer: RTL and testbench

//   Upstream feeder for the bit-serial streaming multiplier. Accepts one parallel

---
 rtl/streaming_operand_serializer.sv | 141 ++++++++++++++
 tb/tb_streaming_operand_serializer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/streaming_operand_serializer.sv
// Purpose: LSB-first serializer for an operand pair (A,B), WIDTH data beats then WIDTH pad beats.
// Latency: first beat valid the cycle after accept; 2*WIDTH+1 cycles accept-to-accept at full rate.
// Backpressure: ser_ready=0 freezes all state and outputs; in_ready only while idle.
// Option: define SIGNED_EXT_EN to pad with the captured operand sign bits instead of zeros.
module streaming_operand_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  localparam int CW = $clog2(2*WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(2*WIDTH - 1);
  localparam logic [CW-1:0] DATA_BEATS = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAD   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sh_a_nxt;
  logic [WIDTH-1:0] sh_b_nxt;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             pad_a;
  logic             pad_b;

`ifdef SIGNED_EXT_EN
  logic sign_a;
  logic sign_b;

  // Capture operand sign bits at accept; they feed the pad half of the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_a <= 1'b0;
      sign_b <= 1'b0;
    end else if (in_valid && in_ready) begin
      sign_a <= in_a[WIDTH-1];
      sign_b <= in_b[WIDTH-1];
    end
  end

  assign pad_a = sign_a;
  assign pad_b = sign_b;
`else
  assign pad_a = 1'b0;
  assign pad_b = 1'b0;
`endif

  // Ready is a pure decode of the state register; busy is its complement.
  assign in_ready = (state == IDLE);
  assign busy     = ~in_ready;

  // Next shift-register contents: shift right, filling the top with the pad bit,
  // so after WIDTH shifts bit 0 naturally carries the pad value.
  always_comb begin
    sh_a_nxt = '0;
    sh_b_nxt = '0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      sh_a_nxt[i] = sh_a[i+1];
      sh_b_nxt[i] = sh_b[i+1];
    end
    sh_a_nxt[WIDTH-1] = pad_a;
    sh_b_nxt[WIDTH-1] = pad_b;
    count_nxt = count + CW'(1);
  end

  // Frame FSM with registered serial outputs; no state moves without a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sh_a      <= '0;
      sh_b      <= '0;
      count     <= '0;
      ser_valid <= 1'b0;
      ser_a     <= 1'b0;
      ser_b     <= 1'b0;
      ser_first <= 1'b0;
      ser_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state     <= SHIFT;
            sh_a      <= in_a;
            sh_b      <= in_b;
            count     <= '0;
            ser_valid <= 1'b1;
            ser_a     <= in_a[0];
            ser_b     <= in_b[0];
            ser_first <= 1'b1;
            ser_last  <= 1'b0;
          end
        end
        SHIFT, PAD: begin
          if (ser_ready) begin
            if (count == LAST_BEAT) begin
              // Final beat consumed: drop to idle, one-cycle bubble before next accept.
              state     <= IDLE;
              count     <= '0;
              ser_valid <= 1'b0;
              ser_a     <= 1'b0;
              ser_b     <= 1'b0;
              ser_first <= 1'b0;
              ser_last  <= 1'b0;
            end else begin
              state     <= (count_nxt < DATA_BEATS) ? SHIFT : PAD;
              sh_a      <= sh_a_nxt;
              sh_b      <= sh_b_nxt;
              count     <= count_nxt;
              ser_a     <= sh_a_nxt[0];
              ser_b     <= sh_b_nxt[0];
              ser_first <= 1'b0;
              ser_last  <= (count_nxt == LAST_BEAT);
            end
          end
        end
        default: begin
          state     <= IDLE;
          ser_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_streaming_operand_serializer.sv
// Scoreboard bench for streaming_operand_serializer at WIDTH=8.
// Stimulus pushes expected beats per accepted pair; a negedge monitor pops and compares.
module tb_streaming_operand_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_valid;
  logic       in_ready;
  logic       ser_a;
  logic       ser_b;
  logic       ser_valid;
  logic       ser_ready;
  logic       ser_first;
  logic       ser_last;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [3:0] exp_q[$];

  streaming_operand_serializer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
    .in_ready(in_ready), .ser_a(ser_a), .ser_b(ser_b), .ser_valid(ser_valid),
    .ser_ready(ser_ready), .ser_first(ser_first), .ser_last(ser_last), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected frame: beat i carries {a_bit, b_bit, first, last}.
  task automatic push_frame(input logic [7:0] a, input logic [7:0] b);
    logic pa;
    logic pb;
`ifdef SIGNED_EXT_EN
    pa = a[7];
    pb = b[7];
`else
    pa = 1'b0;
    pb = 1'b0;
`endif
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({(i < 8) ? a[i[2:0]] : pa, (i < 8) ? b[i[2:0]] : pb,
                       1'(i == 0), 1'(i == 15)});
    end
  endtask

  // Present a pair and hold in_valid until accepted; returns accept cycle.
  task automatic accept_pair(input logic [7:0] a, input logic [7:0] b, output int acc_cyc);
    int waited;
    bit ok;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    waited = 0;
    ok = 1'b0;
    while (!ok && waited < 100) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else waited++;
    end
    if (!ok) check("accept_timeout", 16'(waited), 16'd0);
    @(posedge clk);
    push_frame(a, b);
    #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    while (waited < 100) begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
    end
    if (waited >= 100) check("idle_timeout", 16'(waited), 16'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every consumed beat must match the head of the scoreboard.
  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("busy_vs_ready", {15'd0, busy}, {15'd0, ~in_ready});
        if (ser_valid && ser_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", {12'd0, ser_a, ser_b, ser_first, ser_last}, 16'hFFFF);
          end else begin
            e = exp_q.pop_front();
            check("beat", {12'd0, ser_a, ser_b, ser_first, ser_last}, {12'd0, e});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, t3, t4, t5;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = 8'h00;
    in_b = 8'h00;
    ser_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state and idle behaviour.
    @(negedge clk);
    check("rst_in_ready", {15'd0, in_ready}, 16'd1);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_ser_outs", {11'd0, ser_valid, ser_a, ser_b, ser_first, ser_last}, 16'd0);
    repeat (3) begin
      @(negedge clk);
      check("idle_no_valid", {15'd0, ser_valid}, 16'd0);
    end
    @(posedge clk);
    #1;

    // A5/3C frame, then 0xFF pair held valid throughout it.
    accept_pair(8'hA5, 8'h3C, t1);
    @(negedge clk);
    check("hand_beat0", {12'd0, ser_a, ser_b, ser_first, ser_last}, 16'b1010);
    check("hand_busy", {15'd0, in_ready}, 16'd0);
    @(posedge clk);
    #1;
    accept_pair(8'hFF, 8'hFF, t2);
    check("accept_interval", 16'(t2 - t1), 16'd17);
    wait_idle();

    // Backpressure for 3 cycles at beat 5.
    accept_pair(8'hA5, 8'h3C, t3);
    repeat (5) @(posedge clk);
    #1;
    ser_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_hold", {11'd0, ser_valid, ser_a, ser_b, ser_first, ser_last}, 16'b11100);
    end
    @(posedge clk);
    #1;
    ser_ready = 1'b1;

    // Sign-extension vector, accepted as early as possible after the stalled frame.
    accept_pair(8'h80, 8'h7F, t4);
    check("stall_interval", 16'(t4 - t3), 16'd20);
    wait_idle();

    // Reset in the middle of a frame.
    accept_pair(8'h3C, 8'hA5, t5);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_valid", {15'd0, ser_valid}, 16'd0);
    check("abort_ready", {15'd0, in_ready}, 16'd1);
    check("abort_last", {15'd0, ser_last}, 16'd0);
    @(posedge clk);
    #1;
    accept_pair(8'h01, 8'h00, t5);
    @(negedge clk);
    check("post_abort_first", {13'd0, ser_valid, ser_a, ser_first}, 16'b111);
    @(posedge clk);
    #1;
    wait_idle();
    repeat (3) @(posedge clk);
    check("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
